// File: rtl/rob_multi_retire_pkg.sv
// Shared ROB configuration defaults and entry payload/status types.
package rob_multi_retire_pkg;

    localparam int unsigned ROB_ENTRIES      = 16;
    localparam int unsigned ROB_NUM_WB       = 4;
    localparam int unsigned ROB_RETIRE_WIDTH = 2;
    localparam int unsigned ROB_PREG_W       = 6;
    localparam int unsigned ROB_IDX_W        = $clog2(ROB_ENTRIES);
    localparam logic [31:0] ROB_EXC_VECTOR   = 32'h0000_0100;

    // Per-entry payload; not reset, always qualified by the status bits
    typedef struct packed {
        logic [4:0]            dest_reg;
        logic [ROB_PREG_W-1:0] dest_preg;
        logic                  wb_en;
        logic [31:0]           pc;
        logic [31:0]           target;
        logic                  mispred;
        logic                  exception;
    } rob_entry_t;

    typedef struct packed {
        logic        valid;
        logic        ready;
        logic [31:0] result;
    } rob_status_t;

endpackage

// File: rtl/rob_multi_retire_if.sv
// Dispatch, writeback and commit bundle of the reorder buffer.
interface rob_multi_retire_if #(
    parameter int unsigned ENTRIES      = rob_multi_retire_pkg::ROB_ENTRIES,
    parameter int unsigned NUM_WB       = rob_multi_retire_pkg::ROB_NUM_WB,
    parameter int unsigned RETIRE_WIDTH = rob_multi_retire_pkg::ROB_RETIRE_WIDTH
);
    localparam int unsigned IDX_W  = $clog2(ENTRIES);
    localparam int unsigned PREG_W = rob_multi_retire_pkg::ROB_PREG_W;

    logic                         disp_valid;
    logic                         disp_ready;
    logic [4:0]                   disp_areg;
    logic [PREG_W-1:0]            disp_preg;
    logic                         disp_wb_en;
    logic [31:0]                  disp_pc;
    logic [IDX_W-1:0]             disp_idx;

    logic [NUM_WB-1:0]            wb_valid;
    logic [NUM_WB*IDX_W-1:0]      wb_idx;
    logic [NUM_WB*32-1:0]         wb_result;
    logic [NUM_WB-1:0]            wb_mispred;
    logic [NUM_WB*32-1:0]         wb_target;
    logic [NUM_WB-1:0]            wb_exception;

    logic [RETIRE_WIDTH-1:0]        commit_valid;
    logic [RETIRE_WIDTH-1:0]        commit_wb_en;
    logic [RETIRE_WIDTH*5-1:0]      commit_areg;
    logic [RETIRE_WIDTH*PREG_W-1:0] commit_preg;
    logic [RETIRE_WIDTH*32-1:0]     commit_result;
    logic                           flush;
    logic [31:0]                    flush_pc;

    modport master (
        output disp_valid, disp_areg, disp_preg, disp_wb_en, disp_pc,
        output wb_valid, wb_idx, wb_result, wb_mispred, wb_target, wb_exception,
        input  disp_ready, disp_idx,
        input  commit_valid, commit_wb_en, commit_areg, commit_preg, commit_result,
        input  flush, flush_pc
    );

    modport slave (
        input  disp_valid, disp_areg, disp_preg, disp_wb_en, disp_pc,
        input  wb_valid, wb_idx, wb_result, wb_mispred, wb_target, wb_exception,
        output disp_ready, disp_idx,
        output commit_valid, commit_wb_en, commit_areg, commit_preg, commit_result,
        output flush, flush_pc
    );

endinterface

// File: rtl/rob_retire_sel.sv
// In-order retire selection over the head window: commit mask, flush slot, commit count.
module rob_retire_sel #(
    parameter int unsigned RETIRE_WIDTH = 2,
    parameter int unsigned CNT_W        = $clog2(RETIRE_WIDTH + 1)
) (
    input  logic [RETIRE_WIDTH-1:0] valid,
    input  logic [RETIRE_WIDTH-1:0] ready,
    input  logic [RETIRE_WIDTH-1:0] inrange,
    input  logic [RETIRE_WIDTH-1:0] mispred,
    input  logic [RETIRE_WIDTH-1:0] exception,
    output logic [RETIRE_WIDTH-1:0] commit_mask,
    output logic [RETIRE_WIDTH-1:0] flush_oh,
    output logic [CNT_W-1:0]        commit_cnt
);

    logic alive;

    // alive: every older slot retired cleanly and this slot is complete
    always_comb begin
        commit_mask = '0;
        flush_oh    = '0;
        commit_cnt  = '0;
        alive       = 1'b1;
        for (int k = 0; k < int'(RETIRE_WIDTH); k++) begin
            alive          = alive & valid[k] & ready[k] & inrange[k];
            flush_oh[k]    = alive & (mispred[k] | exception[k]);
            commit_mask[k] = alive & ~exception[k];
            if (commit_mask[k]) begin
                commit_cnt = commit_cnt + CNT_W'(1);
            end
            alive          = alive & ~mispred[k] & ~exception[k];
        end
    end

endmodule

// File: rtl/rob_multi_retire.sv
// Reorder buffer: in-order dispatch, out-of-order writeback, multi-wide in-order retire.
module rob_multi_retire
    import rob_multi_retire_pkg::*;
#(
    parameter int unsigned ENTRIES      = ROB_ENTRIES,
    parameter int unsigned NUM_WB       = ROB_NUM_WB,
    parameter int unsigned RETIRE_WIDTH = ROB_RETIRE_WIDTH,
    parameter logic [31:0] EXC_VECTOR   = ROB_EXC_VECTOR
) (
    input logic              clk,
    input logic              rst_n,
    rob_multi_retire_if.slave bus
);

    localparam int unsigned IDX_W  = $clog2(ENTRIES);
    localparam int unsigned CNT_W  = $clog2(ENTRIES + 1);
    localparam int unsigned RCNT_W = $clog2(RETIRE_WIDTH + 1);
    localparam int unsigned PREG_W = ROB_PREG_W;

    rob_entry_t  ent [ENTRIES];
    rob_status_t st  [ENTRIES];
    logic [IDX_W-1:0] head, tail;
    logic [CNT_W-1:0] count;

    logic [IDX_W-1:0]        slot_idx [RETIRE_WIDTH];
    logic [IDX_W-1:0]        wb_tag   [NUM_WB];
    logic [NUM_WB-1:0]       wb_hit;
    logic [RETIRE_WIDTH-1:0] win_valid, win_ready, win_inrange, win_mispred, win_exc;
    logic [RETIRE_WIDTH-1:0] commit_mask, flush_oh;
    logic [RCNT_W-1:0]       commit_cnt;
    logic                    flush, disp_ready, disp_fire;
    logic [31:0]             flush_pc;
    logic [RETIRE_WIDTH-1:0]        c_wb_en;
    logic [RETIRE_WIDTH*5-1:0]      c_areg;
    logic [RETIRE_WIDTH*PREG_W-1:0] c_preg;
    logic [RETIRE_WIDTH*32-1:0]     c_result;
    logic                           unused_pc;

    // Head window gathered from registered state only
    always_comb begin
        slot_idx    = '{default: '0};
        win_valid   = '0;
        win_ready   = '0;
        win_inrange = '0;
        win_mispred = '0;
        win_exc     = '0;
        for (int k = 0; k < int'(RETIRE_WIDTH); k++) begin
            slot_idx[k]    = head + IDX_W'(k);
            win_valid[k]   = st[slot_idx[k]].valid;
            win_ready[k]   = st[slot_idx[k]].ready;
            win_inrange[k] = CNT_W'(k) < count;
            win_mispred[k] = ent[slot_idx[k]].mispred;
            win_exc[k]     = ent[slot_idx[k]].exception;
        end
    end

    rob_retire_sel #(
        .RETIRE_WIDTH (RETIRE_WIDTH),
        .CNT_W        (RCNT_W)
    ) u_sel (
        .valid       (win_valid),
        .ready       (win_ready),
        .inrange     (win_inrange),
        .mispred     (win_mispred),
        .exception   (win_exc),
        .commit_mask (commit_mask),
        .flush_oh    (flush_oh),
        .commit_cnt  (commit_cnt)
    );

    assign flush      = |flush_oh;
    assign disp_ready = (count != CNT_W'(ENTRIES)) && !flush;
    assign disp_fire  = bus.disp_valid && disp_ready;

    always_comb begin
        flush_pc = '0;
        c_wb_en  = '0;
        c_areg   = '0;
        c_preg   = '0;
        c_result = '0;
        for (int k = 0; k < int'(RETIRE_WIDTH); k++) begin
            if (flush_oh[k]) begin
                flush_pc = win_exc[k] ? EXC_VECTOR : ent[slot_idx[k]].target;
            end
            c_wb_en[k]               = ent[slot_idx[k]].wb_en;
            c_areg[k*5 +: 5]         = ent[slot_idx[k]].dest_reg;
            c_preg[k*PREG_W +: PREG_W] = ent[slot_idx[k]].dest_preg;
            c_result[k*32 +: 32]     = st[slot_idx[k]].result;
        end
    end

    // Writebacks only land on currently allocated entries
    always_comb begin
        wb_tag = '{default: '0};
        wb_hit = '0;
        for (int p = 0; p < int'(NUM_WB); p++) begin
            wb_tag[p] = bus.wb_idx[p*IDX_W +: IDX_W];
            wb_hit[p] = bus.wb_valid[p] && st[wb_tag[p]].valid;
        end
    end

    assign unused_pc          = ^ent[head].pc;
    assign bus.disp_ready     = disp_ready;
    assign bus.disp_idx       = tail;
    assign bus.commit_valid   = commit_mask;
    assign bus.commit_wb_en   = c_wb_en;
    assign bus.commit_areg    = c_areg;
    assign bus.commit_preg    = c_preg;
    assign bus.commit_result  = c_result;
    assign bus.flush          = flush;
    assign bus.flush_pc       = flush_pc;

    // Status and pointers; descending port loop lets the lowest port win a collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) st[i] <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                st[i].valid <= 1'b0;
                st[i].ready <= 1'b0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (disp_fire) begin
                st[tail].valid <= 1'b1;
                st[tail].ready <= 1'b0;
                tail           <= tail + IDX_W'(1);
            end
            for (int p = int'(NUM_WB) - 1; p >= 0; p--) begin
                if (wb_hit[p]) begin
                    st[wb_tag[p]].ready  <= 1'b1;
                    st[wb_tag[p]].result <= bus.wb_result[p*32 +: 32];
                end
            end
            for (int k = 0; k < int'(RETIRE_WIDTH); k++) begin
                if (commit_mask[k]) begin
                    st[slot_idx[k]].valid <= 1'b0;
                    st[slot_idx[k]].ready <= 1'b0;
                end
            end
            head  <= head + IDX_W'(commit_cnt);
            count <= count + CNT_W'(disp_fire) - CNT_W'(commit_cnt);
        end
    end

    // Payload array, no reset needed
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (disp_fire) begin
                ent[tail].dest_reg  <= bus.disp_areg;
                ent[tail].dest_preg <= bus.disp_preg;
                ent[tail].wb_en     <= bus.disp_wb_en;
                ent[tail].pc        <= bus.disp_pc;
                ent[tail].mispred   <= 1'b0;
                ent[tail].exception <= 1'b0;
            end
            for (int p = int'(NUM_WB) - 1; p >= 0; p--) begin
                if (wb_hit[p]) begin
                    ent[wb_tag[p]].mispred   <= bus.wb_mispred[p];
                    ent[wb_tag[p]].exception <= bus.wb_exception[p];
                    ent[wb_tag[p]].target    <= bus.wb_target[p*32 +: 32];
                end
            end
        end
    end

endmodule

// File: tb/tb_rob_multi_retire.sv
// Directed and randomized checks of rob_multi_retire against a queue-based program-order model.
module tb_rob_multi_retire;

    localparam int unsigned ENT = 8;
    localparam int unsigned NWB = 2;
    localparam int unsigned RW  = 2;
    localparam int unsigned IW  = $clog2(ENT);
    localparam int unsigned PW  = rob_multi_retire_pkg::ROB_PREG_W;
    localparam logic [31:0] EXC = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rob_multi_retire_if #(.ENTRIES(ENT), .NUM_WB(NWB), .RETIRE_WIDTH(RW)) bus ();

    rob_multi_retire #(
        .ENTRIES(ENT), .NUM_WB(NWB), .RETIRE_WIDTH(RW), .EXC_VECTOR(EXC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          idx;
        logic [4:0]  areg;
        logic [PW-1:0] preg;
        logic        wb_en;
        bit          ready;
        logic [31:0] result;
        bit          mis;
        bit          exc;
        logic [31:0] tgt;
    } m_ent_t;

    m_ent_t      mq[$];
    int          m_tail;
    logic [31:0] next_pc;
    int          total = 0;
    int          bad   = 0;

    bit          d_valid;
    logic [4:0]  d_areg;
    logic [PW-1:0] d_preg;
    logic        d_wben;
    bit          w_valid[NWB];
    int          w_idx[NWB];
    logic [31:0] w_res[NWB];
    logic [31:0] w_tgt[NWB];
    bit          w_mis[NWB];
    bit          w_exc[NWB];

    int          exp_n;
    bit          exp_flush;
    logic [31:0] exp_fpc;
    bit          exp_ready;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Oldest-first walk of the program-order queue
    function automatic void model_eval();
        exp_n     = 0;
        exp_flush = 1'b0;
        exp_fpc   = '0;
        for (int k = 0; k < int'(RW); k++) begin
            if (k >= mq.size() || !mq[k].ready) break;
            if (mq[k].exc) begin
                exp_flush = 1'b1;
                exp_fpc   = EXC;
                break;
            end
            exp_n++;
            if (mq[k].mis) begin
                exp_flush = 1'b1;
                exp_fpc   = mq[k].tgt;
                break;
            end
        end
        exp_ready = (mq.size() < int'(ENT)) && !exp_flush;
    endfunction

    task automatic idle();
        d_valid = 1'b0;
        d_areg  = '0;
        d_preg  = '0;
        d_wben  = 1'b0;
        for (int p = 0; p < int'(NWB); p++) begin
            w_valid[p] = 1'b0; w_idx[p] = 0; w_res[p] = '0;
            w_tgt[p] = '0; w_mis[p] = 1'b0; w_exc[p] = 1'b0;
        end
    endtask

    task automatic set_wb(input int p, input int idx, input logic [31:0] res,
                          input bit mis, input bit exc, input logic [31:0] tgt);
        w_valid[p] = 1'b1; w_idx[p] = idx; w_res[p] = res;
        w_mis[p] = mis; w_exc[p] = exc; w_tgt[p] = tgt;
    endtask

    task automatic drive_bus();
        bus.disp_valid = d_valid;
        bus.disp_areg  = d_areg;
        bus.disp_preg  = d_preg;
        bus.disp_wb_en = d_wben;
        bus.disp_pc    = next_pc;
        for (int p = 0; p < int'(NWB); p++) begin
            bus.wb_valid[p]           = w_valid[p];
            bus.wb_idx[p*IW +: IW]    = IW'(w_idx[p]);
            bus.wb_result[p*32 +: 32] = w_res[p];
            bus.wb_mispred[p]         = w_mis[p];
            bus.wb_exception[p]       = w_exc[p];
            bus.wb_target[p*32 +: 32] = w_tgt[p];
        end
    endtask

    // Called at a negedge: compare outputs, apply stimulus, advance model across the edge
    task automatic cycle();
        m_ent_t e;
        model_eval();
        check("disp_ready", 64'(bus.disp_ready), 64'(exp_ready));
        check("disp_idx", 64'(bus.disp_idx), 64'(m_tail));
        check("commit_valid", 64'(bus.commit_valid), 64'((1 << exp_n) - 1));
        check("flush", 64'(bus.flush), 64'(exp_flush));
        check("flush_pc", 64'(bus.flush_pc), 64'(exp_fpc));
        for (int k = 0; k < exp_n; k++) begin
            check("commit_areg", 64'(bus.commit_areg[k*5 +: 5]), 64'(mq[k].areg));
            check("commit_preg", 64'(bus.commit_preg[k*PW +: PW]), 64'(mq[k].preg));
            check("commit_wb_en", 64'(bus.commit_wb_en[k]), 64'(mq[k].wb_en));
            check("commit_result", 64'(bus.commit_result[k*32 +: 32]), 64'(mq[k].result));
        end
        drive_bus();
        if (exp_flush) begin
            mq.delete();
            m_tail = 0;
        end else begin
            for (int p = int'(NWB) - 1; p >= 0; p--) begin
                if (w_valid[p]) begin
                    foreach (mq[j]) begin
                        if (mq[j].idx == w_idx[p]) begin
                            mq[j].ready = 1'b1; mq[j].result = w_res[p];
                            mq[j].mis = w_mis[p]; mq[j].exc = w_exc[p]; mq[j].tgt = w_tgt[p];
                        end
                    end
                end
            end
            for (int k = 0; k < exp_n; k++) void'(mq.pop_front());
            if (d_valid && exp_ready) begin
                e.idx = m_tail; e.areg = d_areg; e.preg = d_preg; e.wb_en = d_wben;
                e.ready = 1'b0; e.result = '0; e.mis = 1'b0; e.exc = 1'b0; e.tgt = '0;
                mq.push_back(e);
                m_tail  = (m_tail + 1) % int'(ENT);
                next_pc = next_pc + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        drive_bus();
        mq.delete();
        m_tail  = 0;
        next_pc = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic rand_disp();
        d_valid = 1'b1;
        d_areg  = 5'($urandom);
        d_preg  = PW'($urandom);
        d_wben  = 1'($urandom);
    endtask

    task automatic stream_stim();
        int n;
        idle();
        rand_disp();
        n = 0;
        foreach (mq[j]) begin
            if (!mq[j].ready && n < int'(NWB)) begin
                set_wb(n, mq[j].idx, $urandom, 1'b0, 1'b0, '0);
                n++;
            end
        end
    endtask

    task automatic gen_random();
        int cand[$];
        int s;
        idle();
        if ($urandom % 4 != 0) rand_disp();
        foreach (mq[j]) if (!mq[j].ready) cand.push_back(mq[j].idx);
        for (int p = 0; p < int'(NWB); p++) begin
            if ($urandom % 2 == 1) begin
                if ($urandom % 10 == 0) begin
                    set_wb(p, int'($urandom % ENT), $urandom, ($urandom % 12 == 0),
                           ($urandom % 20 == 0), $urandom & 32'hFFFF_FFFC);
                end else if (cand.size() > 0) begin
                    s = int'($urandom % cand.size());
                    set_wb(p, cand[s], $urandom, ($urandom % 12 == 0),
                           ($urandom % 20 == 0), $urandom & 32'hFFFF_FFFC);
                    cand.delete(s);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        mq.delete();
        m_tail  = 0;
        next_pc = '0;
        drive_bus();
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(bus.disp_ready), 64'd1);
        check("rst_idx", 64'(bus.disp_idx), 64'd0);
        check("rst_cv", 64'(bus.commit_valid), 64'd0);
        check("rst_flush", 64'(bus.flush), 64'd0);
        check("rst_fpc", 64'(bus.flush_pc), 64'd0);
        rst_n = 1'b1;

        // Fill to capacity, then one rejected dispatch
        for (int i = 0; i < int'(ENT); i++) begin
            idle(); rand_disp(); cycle();
        end
        check("full_ready", 64'(bus.disp_ready), 64'd0);
        idle(); rand_disp(); cycle();
        check("full_idx", 64'(bus.disp_idx), 64'd0);

        // Out-of-order writeback, then paired retire
        idle(); set_wb(0, 1, 32'hAA, 1'b0, 1'b0, '0); cycle();
        check("wait_cv", 64'(bus.commit_valid), 64'd0);
        idle(); set_wb(0, 0, 32'hBB, 1'b0, 1'b0, '0); cycle();
        check("pair_cv", 64'(bus.commit_valid), 64'd3);
        check("pair_res0", 64'(bus.commit_result[31:0]), 64'hBB);
        check("pair_res1", 64'(bus.commit_result[63:32]), 64'hAA);

        // Streaming with pointer wrap
        for (int i = 0; i < 20; i++) begin
            stream_stim(); cycle();
        end

        // Mispredict on the second slot
        do_reset();
        idle(); rand_disp(); cycle(); cycle();
        idle();
        set_wb(0, 0, 32'h11, 1'b0, 1'b0, '0);
        set_wb(1, 1, 32'h22, 1'b1, 1'b0, 32'h400);
        cycle();
        check("mp_cv", 64'(bus.commit_valid), 64'd3);
        check("mp_flush", 64'(bus.flush), 64'd1);
        check("mp_fpc", 64'(bus.flush_pc), 64'h400);
        idle(); cycle();
        check("mp_post_ready", 64'(bus.disp_ready), 64'd1);
        check("mp_post_idx", 64'(bus.disp_idx), 64'd0);
        check("mp_post_flush", 64'(bus.flush), 64'd0);

        // Exception at head, dispatch during flush is dropped
        idle(); rand_disp(); cycle(); cycle();
        idle(); set_wb(0, 0, 32'h33, 1'b0, 1'b1, '0); cycle();
        check("exc_cv", 64'(bus.commit_valid), 64'd0);
        check("exc_flush", 64'(bus.flush), 64'd1);
        check("exc_fpc", 64'(bus.flush_pc), 64'(EXC));
        idle(); rand_disp(); cycle();
        check("drop_idx", 64'(bus.disp_idx), 64'd0);
        check("drop_cv", 64'(bus.commit_valid), 64'd0);
        check("drop_flush", 64'(bus.flush), 64'd0);

        // Asynchronous reset with five live entries
        idle(); rand_disp(); repeat (5) cycle();
        idle();
        set_wb(0, 0, 32'h44, 1'b0, 1'b0, '0);
        set_wb(1, 1, 32'h55, 1'b1, 1'b0, 32'h800);
        cycle();
        rst_n = 1'b0;
        idle();
        drive_bus();
        mq.delete();
        m_tail  = 0;
        next_pc = '0;
        #1;
        check("mr_cv", 64'(bus.commit_valid), 64'd0);
        check("mr_flush", 64'(bus.flush), 64'd0);
        check("mr_ready", 64'(bus.disp_ready), 64'd1);
        check("mr_idx", 64'(bus.disp_idx), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(); cycle();
        check("mr_post_cv", 64'(bus.commit_valid), 64'd0);
        check("mr_post_idx", 64'(bus.disp_idx), 64'd0);
        idle(); rand_disp(); cycle();
        check("mr_new_idx", 64'(bus.disp_idx), 64'd1);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            gen_random(); cycle();
        end
        idle(); drive_bus();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rob_multi_retire.md
Name: rob_multi_retire

Overview:
- Parametrised reorder buffer for the out-of-order core. Successor to the fixed 16-entry, single-retire ROB.
- Sits between dispatch (allocates one entry per cycle, in program order) and the FUs (NUM_WB writeback ports, out of order).
- Retires up to RETIRE_WIDTH completed head entries per cycle in order.
- Raises a one-cycle flush with redirect PC when a retiring entry is mispredicted or excepting.

Parameters:
- ENTRIES, 16, ROB depth; power of two, >= 4.
- NUM_WB, 4, writeback ports (one per FU).
- RETIRE_WIDTH, 2, maximum commits per cycle; 1..4, <= ENTRIES.
- PREG_W, 6, physical register tag width ($clog2(NUM_PREGS)).
- EXC_VECTOR, 32'h0000_0100, redirect PC on exception.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- disp_valid_i  in  1  dispatch request
- disp_ready_o  out  1  entry available this cycle
- disp_areg_i  in  5  architectural destination
- disp_preg_i  in  PREG_W  physical destination
- disp_wb_en_i  in  1  instruction writes a register
- disp_pc_i  in  32  instruction PC
- disp_idx_o  out  IDX_W  index allocated (= tail); IDX_W = $clog2(ENTRIES)
- wb_valid_i  in  NUM_WB  writeback strobes
- wb_idx_i  in  NUM_WB*IDX_W  target ROB index per port
- wb_result_i  in  NUM_WB*32  result per port
- wb_mispred_i  in  NUM_WB  branch mispredicted
- wb_target_i  in  NUM_WB*32  correct branch target
- wb_exception_i  in  NUM_WB  instruction excepted
- commit_valid_o  out  RETIRE_WIDTH  slot k retires this cycle
- commit_wb_en_o  out  RETIRE_WIDTH  slot k writes the ARF
- commit_areg_o  out  RETIRE_WIDTH*5  architectural destination
- commit_preg_o  out  RETIRE_WIDTH*PREG_W  physical destination
- commit_result_o  out  RETIRE_WIDTH*32  result value
- flush_o  out  1  pipeline flush
- flush_pc_o  out  32  redirect PC

Behaviour:
- State:
  - Entry array: valid, ready, mispred, exception, areg, preg, wb_en, pc, result, target.
  - head and tail pointers: IDX_W bits, wrap naturally modulo ENTRIES.
  - count: $clog2(ENTRIES+1) bits.
- Reset (rst_n low, async): all valid/ready cleared; head = tail = count = 0.
  - Outputs while in reset and immediately after: disp_ready_o=1, disp_idx_o=0, commit_valid_o=0, flush_o=0, flush_pc_o=0.
  - Reset mid-operation discards all entries; no commit or flush is emitted.
- Dispatch:
  - disp_ready_o = (count != ENTRIES) && !flush_o.
  - On disp_valid_i && disp_ready_o, the entry at tail is written with valid=1, ready=0 and the flags cleared; tail increments.
  - A slot freed by a same-cycle commit is not visible until the next cycle.
- Writeback:
  - Port p with wb_valid_i[p] sets ready, result, mispred, exception and target of entry wb_idx_i[p] at the clock edge.
  - Writes to an invalid entry are ignored.
  - Two ports hitting the same index is illegal; the lowest port number wins.
  - Writeback is not bypassed into the same-cycle commit decision; an entry is retirable one cycle after writeback.
- Commit (combinational from registered state):
  - Slot k (k = 0..RETIRE_WIDTH-1) examines entry head+k, with wrap.
  - commit_valid_o[k] = 1 iff entries head..head+k are all valid and ready, k < count, and no slot j<k is mispred or exception.
  - An excepting entry does not commit: its commit_valid_o is 0, while flush_o=1 and flush_pc_o=EXC_VECTOR.
  - A mispredicting entry commits, then flush_o=1 and flush_pc_o = its target.
  - Slots after the first mispred/exception slot are suppressed.
  - Only the first flush-causing slot drives flush_pc_o.
- Edge update:
  - Without flush: head += number of committed slots; count += dispatched - committed.
  - With flush_o: all entries invalidated, head = tail = count = 0; same-cycle dispatch and writebacks are dropped.
  - flush_o lasts exactly one cycle per event.
- Full with simultaneous commit: dispatch stalls this cycle and proceeds next cycle.
- Empty: commit_valid_o=0, flush_o=0.

Decomposition:
- Shared package (CORE_PKG):
  - ROB_ENTRIES, RETIRE_WIDTH, NUM_WB, EXC_VECTOR, ROB_IDX_W = $clog2(ROB_ENTRIES).
  - Widened rob_entry_t: dest_reg, dest_preg, wb_en, pc, target, mispred, exception.
  - rob_status_t: valid, ready, result.
- One sub-module, rob_retire_sel:
  - Inputs: head-window status and flag vectors.
  - Outputs: commit mask, flush-slot one-hot, commit count.
  - Purely combinational; prefix-AND logic.

Test Plan (ENTRIES=8, NUM_WB=2, RETIRE_WIDTH=2):
- Reset then 8 dispatches PC 0x0..0x1C -> disp_idx_o 0..7, disp_ready_o=0 after 8th; 9th dispatch not accepted.
- Writeback idx 1 then idx 0 (result 0xAA, 0xBB) -> no commit until idx 0 ready. The cycle after idx 0's writeback: commit_valid_o=2'b11, results 0xBB, 0xAA; head=2.
- Fill, retire 2/cycle while dispatching 1/cycle for 20 cycles -> head/tail wrap 7->0, commits in PC order, no loss or duplication.
- Entry 0 ready; entry 1 mispred with target 0x400 -> commit_valid_o=2'b11, flush_o=1, flush_pc_o=0x400. Next cycle count=0, disp_ready_o=1, disp_idx_o=0.
- Entry 0 exception -> commit_valid_o=2'b00, flush_o=1, flush_pc_o=0x100; a dispatch in that cycle is dropped.
- rst_n low for 1 cycle with 5 entries valid -> no commit or flush afterward; count=0; ROB accepts a new dispatch at idx 0.
